uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: AXI-Stream byte channel feeding the UART transmitter
// Signals: tvalid/tdata driven by the producer (master), tready driven by the transmitter (slave)
interface uart_tx_if;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tready;
    modport master (output tvalid, output tdata, input tready);
    modport slave (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry AXIS holding register
// Ports: i_clk clock; i_rst async active-high reset; s_axis byte input (tready = holding register empty);
//        o_txd registered serial line, idle high; o_txd_busy high outside IDLE; o_txd_done end-of-frame pulse
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_tx_if.slave s_axis,
    output logic     o_txd,
    output logic     o_txd_busy,
    output logic     o_txd_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    localparam logic [7:0] CMAX = 8'(CLKS_PER_BIT - 1);
    localparam logic SB_LAST = (STOP_BITS == 2);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n, hold, hold_n, data, data_n;
    logic [2:0] idx, idx_n;
    logic sb, sb_n, full, full_n, txd_n, done_n, rdy, bit_end, par_bit, load;
    assign bit_end = cnt == CMAX;
    assign par_bit = (PARITY == 1) ? ~^data : ^data;
    // rdy holds tready low during reset and releases it on the first edge afterwards
    assign s_axis.tready = rdy & ~full;
    assign o_txd_busy = state != IDLE;
    // A waiting byte starts a new frame from IDLE, or straight out of the last stop bit
    assign load = full & ((state == IDLE) | (state == STOP & bit_end & sb == SB_LAST));
    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? 8'd0 : cnt + 8'd1;
        idx_n   = idx;
        sb_n    = sb;
        data_n  = data;
        hold_n  = hold;
        full_n  = full;
        txd_n   = o_txd;
        done_n  = 1'b0;
        if (s_axis.tvalid && s_axis.tready) begin
            full_n = 1'b1;
            hold_n = s_axis.tdata;
        end
        case (state)
            IDLE: begin
                cnt_n = '0;
                txd_n = 1'b1;
            end
            START: if (bit_end) begin
                state_n = DATA;
                idx_n   = '0;
                txd_n   = data[0];
            end
            DATA: if (bit_end) begin
                idx_n = idx + 3'd1;
                txd_n = data[idx_n];
                if (idx == 3'd7) begin
                    sb_n = 1'b0;
                    if (PARITY != 0) begin
                        state_n = PAR;
                        txd_n   = par_bit;
                    end else begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end
                end
            end
            PAR: if (bit_end) begin
                state_n = STOP;
                sb_n    = 1'b0;
                txd_n   = 1'b1;
            end
            STOP: if (bit_end) begin
                sb_n = 1'b1;
                if (sb == SB_LAST) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                    txd_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                txd_n   = 1'b1;
            end
        endcase
        if (load) begin
            state_n = START;
            cnt_n   = '0;
            data_n  = hold;
            full_n  = 1'b0;
            txd_n   = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sb         <= 1'b0;
            data       <= '0;
            hold       <= '0;
            full       <= 1'b0;
            rdy        <= 1'b0;
            o_txd      <= 1'b1;
            o_txd_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sb         <= sb_n;
            data       <= data_n;
            hold       <= hold_n;
            full       <= full_n;
            rdy        <= 1'b1;
            o_txd      <= txd_n;
            o_txd_done <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx across parity and stop-bit configurations
module tb_uart_tx;
    localparam int C = 16;
    localparam int PAR [4] = '{0, 2, 1, 0};
    localparam int STP [4] = '{1, 1, 1, 2};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] tv = '0;
    logic [3:0] tr, txd, busy, done;
    logic [7:0] td [4];
    logic rx_en = 1'b0;
    logic [7:0] rx_b;
    logic [7:0] rxq [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_if u ();
        assign u.tvalid = tv[g];
        assign u.tdata  = td[g];
        assign tr[g]    = u.tready;
        uart_tx #(.CLKS_PER_BIT(C), .PARITY(PAR[g]), .STOP_BITS(STP[g])) dut (
            .i_clk(clk), .i_rst(rst), .s_axis(u),
            .o_txd(txd[g]), .o_txd_busy(busy[g]), .o_txd_done(done[g]));
    end

    // Expected frame, LSB = first bit on the line; returns the number of bits
    function automatic int build(input logic [7:0] b, input int p, input int s, output logic [11:0] f);
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (p != 0) f[9] = ($countones(b) % 2 == 1) ^ (p == 1);
        return 9 + (p != 0 ? 1 : 0) + s;
    endfunction

    // Behavioural receiver on instance 0: mid-bit sampling
    always begin
        @(posedge clk);
        #1;
        if (rx_en && txd[0] === 1'b0) begin
            for (int i = 0; i < C / 2; i++) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge clk);
                #1;
                rx_b[i] = txd[0];
            end
            repeat (C) @(posedge clk);
            #1;
            checks++;
            if (txd[0] !== 1'b1) begin
                failures++;
                $display("FAIL rx_stop got %b, need 1", txd[0]);
            end
            rxq.push_back(rx_b);
        end
    end

    // Offers b on instance k; returns 1ns after the accepting edge with tvalid still high
    task automatic push(input int k, input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        tv[k] = 1'b1;
        td[k] = b;
        while (tr[k] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 1000) begin
            failures++;
            $display("FAIL push_timeout k=%0d tready got %b, need 1", k, tr[k]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd !== 4'hF || busy !== 4'h0 || done !== 4'h0 || tr !== 4'h0) begin
            failures++;
            $display("FAIL reset_state txd=%b busy=%b done=%b tready=%b, need F/0/0/0", txd, busy, done, tr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (tr !== 4'h0) begin
            failures++;
            $display("FAIL ready_before_edge got %b, need 0000", tr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tr !== 4'hF) begin
            failures++;
            $display("FAIL ready_after_edge got %b, need 1111", tr);
        end
    endtask

    task automatic test_frame(input int k, input logic [7:0] b);
        logic [11:0] f;
        int len;
        logic e;
        len = build(b, PAR[k], STP[k], f) * C;
        push(k, b);
        tv[k] = 1'b0;
        checks++;
        if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || tr[k] !== 1'b0) begin
            failures++;
            $display("FAIL accept_edge k=%0d txd,busy,tready got %b%b%b, need 100", k, txd[k], busy[k], tr[k]);
        end
        for (int j = 1; j <= len + 1; j++) begin
            @(posedge clk);
            #1;
            e = (j <= len) ? f[(j - 1) / C] : 1'b1;
            checks++;
            if (txd[k] !== e) begin
                failures++;
                $display("FAIL frame_txd k=%0d byte=%h cyc=%0d got %b, need %b", k, b, j, txd[k], e);
            end
            checks++;
            if (done[k] !== (j == len + 1)) begin
                failures++;
                $display("FAIL frame_done k=%0d byte=%h cyc=%0d got %b, need %b", k, b, j, done[k], j == len + 1);
            end
            checks++;
            if (busy[k] !== (j <= len)) begin
                failures++;
                $display("FAIL frame_busy k=%0d byte=%h cyc=%0d got %b, need %b", k, b, j, busy[k], j <= len);
            end
            checks++;
            if (tr[k] !== 1'b1) begin
                failures++;
                $display("FAIL frame_ready k=%0d byte=%h cyc=%0d got %b, need 1", k, b, j, tr[k]);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++)
            repeat (3) test_frame(k, 8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [11:0] f1, f2;
        int l1, l2;
        logic e;
        l1 = build(8'h00, 0, 1, f1) * C;
        l2 = build(8'hFF, 0, 1, f2) * C;
        push(0, 8'h00);
        td[0] = 8'hFF;
        for (int j = 1; j <= l1 + l2 + 1; j++) begin
            @(posedge clk);
            #1;
            if (j == 2) tv[0] = 1'b0;
            e = (j <= l1) ? f1[(j - 1) / C] : (j <= l1 + l2) ? f2[(j - 1 - l1) / C] : 1'b1;
            checks++;
            if (txd[0] !== e) begin
                failures++;
                $display("FAIL b2b_txd cyc=%0d got %b, need %b", j, txd[0], e);
            end
            checks++;
            if (tr[0] !== (j == 1 || j > l1)) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got %b, need %b", j, tr[0], j == 1 || j > l1);
            end
            checks++;
            if (done[0] !== (j == l1 + 1 || j == l1 + l2 + 1)) begin
                failures++;
                $display("FAIL b2b_done cyc=%0d got %b, need %b", j, done[0], j == l1 + 1 || j == l1 + l2 + 1);
            end
            checks++;
            if (busy[0] !== (j <= l1 + l2)) begin
                failures++;
                $display("FAIL b2b_busy cyc=%0d got %b, need %b", j, busy[0], j <= l1 + l2);
            end
        end
    endtask

    task automatic test_reset_midframe();
        push(0, 8'h5A);
        tv[0] = 1'b0;
        repeat (20) @(posedge clk);
        push(0, 8'hF0);
        tv[0] = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        checks++;
        if (txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort txd,busy got %b%b, need 01", txd[0], busy[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || tr[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort txd,busy,tready,done got %b%b%b%b, need 1000", txd[0], busy[0], tr[0], done[0]);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL residue cyc=%0d txd,busy got %b%b, need 10", j, txd[0], busy[0]);
            end
        end
        test_frame(0, 8'h55);
    endtask

    task automatic test_loopback();
        logic [7:0] q [$];
        logic [7:0] b, got;
        int t = 0;
        rxq.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            push(0, b);
        end
        tv[0] = 1'b0;
        while (rxq.size() < 256 && t < 400 * C) begin
            @(posedge clk);
            t++;
        end
        rx_en = 1'b0;
        checks++;
        if (rxq.size() != 256) begin
            failures++;
            $display("FAIL loop_count got %0d, need 256", rxq.size());
        end
        for (int i = 0; i < 256; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            checks++;
            if (got !== q[i]) begin
                failures++;
                $display("FAIL loop_byte idx=%0d got %h, need %h", i, got, q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) td[i] = '0;
        test_reset();
        test_frame(0, 8'hA5);
        test_frame(1, 8'hA5);
        test_frame(2, 8'hA5);
        test_frame(3, 8'h3C);
        test_random_frames();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
